// File: rtl/cmp_pkg.sv
// rtl/cmp_pkg.sv - shared comparator function codes and issuer state type
package cmp_pkg;

    localparam logic [1:0] CMP_FUN_NOP = 2'b00;
    localparam logic [1:0] CMP_FUN_EQ  = 2'b01;
    localparam logic [1:0] CMP_FUN_GT  = 2'b10;
    localparam logic [1:0] CMP_FUN_LT  = 2'b11;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        HOLD  = 2'd3
    } iss_state_t;

endpackage

// File: rtl/cmp_watchdog.sv
// rtl/cmp_watchdog.sv - clear/increment 8-bit counter with terminal-count flag
module cmp_watchdog #(
    parameter int TERMINAL = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic i_clr,
    input  logic i_inc,
    output logic o_tc
);

    logic [7:0] r_count;

    // o_tc means "this is the last cycle allowed", so it fires in the TERMINAL-th counted cycle
    assign o_tc = (r_count == 8'(TERMINAL - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count <= 8'd0;
        end else if (i_clr) begin
            r_count <= 8'd0;
        end else if (i_inc && !o_tc) begin
            r_count <= r_count + 8'd1;
        end
    end

endmodule

// File: rtl/cmp_issuer.sv
// rtl/cmp_issuer.sv - single-outstanding comparator issuer; CMP_ISSUER_TIMEOUT_EN adds a WAIT watchdog
module cmp_issuer
    import cmp_pkg::*;
#(
    parameter int WIDTH_IN_DATA  = 16,
    parameter int WIDTH_OUT_DATA = 16,
    parameter int TIMEOUT_CYCLES = 8
) (
    input  logic                      CLK_iss,
    input  logic                      RST_iss,
    input  logic                      req_valid,
    output logic                      req_ready,
    input  logic [WIDTH_IN_DATA-1:0]  req_a,
    input  logic [WIDTH_IN_DATA-1:0]  req_b,
    input  logic [1:0]                req_fun,
    output logic [WIDTH_IN_DATA-1:0]  A_cmp,
    output logic [WIDTH_IN_DATA-1:0]  B_cmp,
    output logic [1:0]                ALU_FUN_cmp,
    output logic                      Cmp_Enable,
    input  logic [WIDTH_OUT_DATA:0]   CMP_OUT,
    input  logic                      CMP_Flag,
    output logic                      rsp_valid,
    input  logic                      rsp_ready,
    output logic [WIDTH_OUT_DATA:0]   rsp_data,
    output logic [1:0]                rsp_fun,
    output logic                      rsp_err
);

    iss_state_t                 r_state;
    iss_state_t                 w_state_nxt;
    logic                       w_accept;
    logic                       w_flag_hit;
    logic                       w_timeout;
    logic                       w_release;
    logic [WIDTH_IN_DATA-1:0]   r_a;
    logic [WIDTH_IN_DATA-1:0]   r_b;
    logic [1:0]                 r_fun;
    logic [1:0]                 r_rsp_fun;
    logic                       r_cmp_enable;
    logic                       r_rsp_valid;
    logic [WIDTH_OUT_DATA:0]    r_rsp_data;

    assign w_accept   = (r_state == IDLE) && req_valid;
    assign w_flag_hit = (r_state == WAIT) && CMP_Flag;
    assign w_release  = (r_state == HOLD) && rsp_ready;

`ifdef CMP_ISSUER_TIMEOUT_EN
    logic w_wd_clr;
    logic w_wd_inc;
    logic w_wd_tc;
    logic r_rsp_err;

    assign w_wd_clr = (r_state == ISSUE);
    assign w_wd_inc = (r_state == WAIT) && !CMP_Flag;

    cmp_watchdog #(
        .TERMINAL (TIMEOUT_CYCLES)
    ) u_watchdog (
        .clk   (CLK_iss),
        .rst   (RST_iss),
        .i_clr (w_wd_clr),
        .i_inc (w_wd_inc),
        .o_tc  (w_wd_tc)
    );

    // A flag arriving on the terminal cycle wins over the timeout
    assign w_timeout = w_wd_inc && w_wd_tc;

    always_ff @(posedge CLK_iss or posedge RST_iss) begin
        if (RST_iss) begin
            r_rsp_err <= 1'b0;
        end else if (w_flag_hit) begin
            r_rsp_err <= 1'b0;
        end else if (w_timeout) begin
            r_rsp_err <= 1'b1;
        end
    end

    assign rsp_err = r_rsp_err;
`else
    logic w_unused_timeout_cfg;

    assign w_unused_timeout_cfg = ^(8'(TIMEOUT_CYCLES));
    assign w_timeout            = 1'b0;
    assign rsp_err              = 1'b0;
`endif

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (req_valid) w_state_nxt = ISSUE;
            ISSUE:   w_state_nxt = WAIT;
            WAIT:    if (CMP_Flag || w_timeout) w_state_nxt = HOLD;
            HOLD:    if (rsp_ready) w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge CLK_iss or posedge RST_iss) begin
        if (RST_iss) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge CLK_iss or posedge RST_iss) begin
        if (RST_iss) begin
            r_a          <= '0;
            r_b          <= '0;
            r_fun        <= 2'b00;
            r_rsp_fun    <= 2'b00;
            r_cmp_enable <= 1'b0;
            r_rsp_valid  <= 1'b0;
            r_rsp_data   <= '0;
        end else begin
            if (w_accept) begin
                r_a       <= req_a;
                r_b       <= req_b;
                r_fun     <= req_fun;
                r_rsp_fun <= req_fun;
            end
            // Enable is high exactly for the ISSUE cycle that follows an accept
            r_cmp_enable <= w_accept;
            if (w_flag_hit) begin
                r_rsp_data  <= CMP_OUT;
                r_rsp_valid <= 1'b1;
            end else if (w_timeout) begin
                r_rsp_data  <= '0;
                r_rsp_valid <= 1'b1;
            end else if (w_release) begin
                r_rsp_valid <= 1'b0;
            end
        end
    end

    assign req_ready   = (r_state == IDLE);
    assign A_cmp       = r_a;
    assign B_cmp       = r_b;
    assign ALU_FUN_cmp = r_fun;
    assign Cmp_Enable  = r_cmp_enable;
    assign rsp_valid   = r_rsp_valid;
    assign rsp_data    = r_rsp_data;
    assign rsp_fun     = r_rsp_fun;

endmodule

// File: doc/cmp_issuer.md
# cmp_issuer

Initiator side of the comparator-unit interface: accepts compare requests from an upstream sequencer over a valid/ready handshake and drives one operation at a time into the comparator. It waits for the comparator's registered flag, captures the result and holds it for a downstream consumer. It sits between the ALU control sequencer and the comparator instance, owning all `Cmp_Enable` timing.

## Interface
- `WIDTH_IN_DATA`, default 16: operand width.
- `WIDTH_OUT_DATA`, default 16: comparator result is `WIDTH_OUT_DATA+1` bits.
- `TIMEOUT_CYCLES`, default 8: WAIT cycles before the watchdog fires (only with `CMP_ISSUER_TIMEOUT_EN`); legal range 2..255.

Ports:
- `CLK_iss`, in, 1: single clock, rising edge.
- `RST_iss`, in, 1: reset, asynchronous, active-high.
- `req_valid`, in, 1: request present.
- `req_ready`, out, 1: issuer can accept.
- `req_a`, `req_b`, in, `WIDTH_IN_DATA` each: operands.
- `req_fun`, in, 2: function code (00 NOP, 01 EQ, 10 GT, 11 LT).
- `A_cmp`, `B_cmp`, out, `WIDTH_IN_DATA` each: operands to comparator, registered.
- `ALU_FUN_cmp`, out, 2: function to comparator, registered.
- `Cmp_Enable`, out, 1: comparator enable, registered.
- `CMP_OUT`, in, `WIDTH_OUT_DATA+1`: comparator result.
- `CMP_Flag`, in, 1: comparator result valid.
- `rsp_valid`, out, 1: response held.
- `rsp_ready`, in, 1: consumer accepts.
- `rsp_data`, out, `WIDTH_OUT_DATA+1`: captured `CMP_OUT`.
- `rsp_fun`, out, 2: function code of this response.
- `rsp_err`, out, 1: watchdog fired; `rsp_data` is 0.

## Operation
- FSM states: IDLE, ISSUE, WAIT, HOLD.
- **IDLE:** `req_ready`=1. On `req_valid && req_ready`:
  - latch `req_a`/`req_b`/`req_fun` into `A_cmp`/`B_cmp`/`ALU_FUN_cmp` and `rsp_fun`;
  - set `Cmp_Enable`=1;
  - go to ISSUE.
- **ISSUE:** exactly one cycle with `Cmp_Enable`=1. Operand registers are stable. Clear `Cmp_Enable` at the exit edge; go to WAIT.
- **WAIT:** sample `CMP_Flag` each cycle. On `CMP_Flag`=1, capture `CMP_OUT` into `rsp_data`, set `rsp_err`=0, set `rsp_valid`=1, and go to HOLD.
- **HOLD:** `rsp_valid`=1, and `rsp_data`/`rsp_fun`/`rsp_err` are stable until `rsp_ready`=1. Then clear `rsp_valid` and go to IDLE.
- `req_ready` is 0 in every state except IDLE. There is only one outstanding operation.
- A `CMP_Flag` seen in IDLE, ISSUE or HOLD is ignored.
- `A_cmp`/`B_cmp`/`ALU_FUN_cmp` keep their last values after an operation completes. They are not cleared.
- Reset values:
  - all outputs 0 except `req_ready`=1;
  - state IDLE, watchdog counter 0.
- Reset mid-operation: return to IDLE immediately, drop `Cmp_Enable` asynchronously and discard any captured result.

## Timing
- Cycle 0: request handshake.
- Cycle 1: ISSUE, `Cmp_Enable`=1.
- Cycle 2: WAIT, with `CMP_Flag`=1 from a conforming comparator.
- Cycle 3: `rsp_valid`=1.
- Request-to-response latency is 3 cycles. Minimum issue interval is 4 cycles when `rsp_ready` is held high.
- `rsp_ready` high in the first HOLD cycle: response consumed in that cycle; IDLE (`req_ready`=1) on cycle 4.
- A stretched comparator (`CMP_Flag` late) extends WAIT cycle-for-cycle.

## Configuration
- Macro: `CMP_ISSUER_TIMEOUT_EN`.
- **Defined:**
  - an 8-bit watchdog counter clears on entering WAIT and increments each WAIT cycle with `CMP_Flag`=0;
  - when it reaches `TIMEOUT_CYCLES`, capture `rsp_data`=0 and `rsp_err`=1, and go to HOLD;
  - if `CMP_Flag`=1 arrives in the same cycle the count is reached, the flag wins and `rsp_err`=0.
- **Undefined:** WAIT persists indefinitely, `rsp_err` is tied to 0, and no counter is synthesized.

## Structure
- Shared package `cmp_pkg` holds:
  - function-code constants `CMP_FUN_NOP`=2'b00, `CMP_FUN_EQ`=2'b01, `CMP_FUN_GT`=2'b10, `CMP_FUN_LT`=2'b11;
  - the issuer state typedef (IDLE/ISSUE/WAIT/HOLD).
- One sub-module, `cmp_watchdog`: clear/increment counter with terminal-count output. It is instantiated only under `CMP_ISSUER_TIMEOUT_EN`.

## Test plan
- **Reset:** assert `RST_iss` mid-WAIT → `Cmp_Enable`=0 and `rsp_valid`=0 asynchronously; `req_ready`=1 after release; no stale response.
- **EQ:** `req_fun`=01, A=5, B=5 → `Cmp_Enable` high for exactly cycle 1; `rsp_valid` on cycle 3; `rsp_data`=1, `rsp_fun`=01, `rsp_err`=0.
- **GT and LT back-to-back:**
  - A=9, B=3, fun 10 → `rsp_data`=2;
  - then A=3, B=9, fun 11 → `rsp_data`=3;
  - with `rsp_ready` held high, the second request is accepted on cycle 4.
- **Backpressure:** fun 00, A=7, B=1, `rsp_ready` held low for 5 cycles → `rsp_data`=0 and `rsp_valid` stable throughout; `req_ready`=0 until the cycle after `rsp_ready` rises.
- **Stretched comparator:** model delays `CMP_Flag` by 3 extra cycles → response on cycle 6 with the correct data; `req_valid` pulses during WAIT are not accepted.
- **Timeout** (macro defined, `TIMEOUT_CYCLES`=8): comparator model never raises `CMP_Flag` → after 8 WAIT cycles `rsp_err`=1, `rsp_data`=0. Repeat with the flag arriving on exactly the 8th WAIT cycle → `rsp_err`=0 with the real data.
